// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between the producer channels, the write arbiter and the dcfifo write port.
// master = producer/FIFO side, slave = arbiter.
interface fifo_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
) ();
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    grant;
  logic               fifo_wr_en;
  logic [DW-1:0]      fifo_din;
  logic               fifo_full;
  logic               fifo_wr_rst_busy;
  logic               burst_done;

  modport master (
    output req_valid, req_data, fifo_full, fifo_wr_rst_busy,
    input  req_ready, grant, fifo_wr_en, fifo_din, burst_done
  );

  modport slave (
    input  req_valid, req_data, fifo_full, fifo_wr_rst_busy,
    output req_ready, grant, fifo_wr_en, fifo_din, burst_done
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one dcfifo write port among NREQ producers.
// Define FIFO_WR_ARB_STATS_EN to add the stall_cnt/stall_clr full-stall counter.
//
// state | meaning
// IDLE  | no owner; pick next valid channel from rr_ptr_q upward
// BURST | channel own_q owns the write port until count, gap or abort
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int BURST_LEN = 16
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef FIFO_WR_ARB_STATS_EN
  input  logic             stall_clr,
  output logic [15:0]      stall_cnt,
`endif
  fifo_wr_arbiter_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [2:0]      rr_ptr_q, rr_ptr_d;
  logic [2:0]      own_q, own_d;
  logic [7:0]      beat_cnt_q, beat_cnt_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            burst_done_q, burst_done_d;

  logic            wr_ok;
  logic            own_valid;
  logic [DW-1:0]   own_data;
  logic            xfer;
  logic            found;
  logic [2:0]      pick;

  assign wr_ok = ~bus.fifo_full & ~bus.fifo_wr_rst_busy;

  // grant_q is all zero outside BURST, so the owner mux also yields zero data when idle
  always_comb begin
    own_valid = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        own_valid = bus.req_valid[i];
        own_data  = bus.req_data[i*DW +: DW];
      end
    end
  end

  assign xfer           = own_valid & wr_ok;
  assign bus.req_ready  = grant_q & {NREQ{wr_ok}};
  assign bus.fifo_wr_en = xfer;
  assign bus.fifo_din   = own_data;
  assign bus.grant      = grant_q;
  assign bus.burst_done = burst_done_q;

  // first pass covers rr_ptr_q..NREQ-1, second pass wraps to the low channels
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && bus.req_valid[j] && (3'(j) >= rr_ptr_q)) begin
        found = 1'b1;
        pick  = 3'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!found && bus.req_valid[j]) begin
        found = 1'b1;
        pick  = 3'(j);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    own_d        = own_q;
    beat_cnt_d   = beat_cnt_q;
    grant_d      = grant_q;
    burst_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.fifo_wr_rst_busy && found) begin
          state_d    = BURST;
          own_d      = pick;
          beat_cnt_d = '0;
          for (int j = 0; j < NREQ; j++) grant_d[j] = (3'(j) == pick);
        end
      end
      BURST: begin
        if (xfer) beat_cnt_d = beat_cnt_q + 8'd1;
        // a full FIFO only stalls; a gap is a missing word while the port could accept one
        if (bus.fifo_wr_rst_busy ||
            (xfer && (beat_cnt_q == 8'(BURST_LEN - 1))) ||
            (wr_ok && !own_valid)) begin
          state_d      = IDLE;
          grant_d      = '0;
          burst_done_d = 1'b1;
          rr_ptr_d     = (own_q == 3'(NREQ - 1)) ? 3'd0 : own_q + 3'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      own_q        <= '0;
      beat_cnt_q   <= '0;
      grant_q      <= '0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      own_q        <= own_d;
      beat_cnt_q   <= beat_cnt_d;
      grant_q      <= grant_d;
      burst_done_q <= burst_done_d;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr) begin
      stall_cnt_d = '0;
    end else if ((state_q == BURST) && own_valid && bus.fifo_full &&
                 (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed producer loads, expected writes/bursts queued,
// a negedge monitor pops and compares on every fifo_wr_en and burst_done.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int BL   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus();

`ifdef FIFO_WR_ARB_STATS_EN
  logic        stall_clr;
  logic [15:0] stall_cnt;
`endif

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST_LEN(BL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef FIFO_WR_ARB_STATS_EN
    .stall_clr (stall_clr),
    .stall_cnt (stall_cnt),
`endif
    .bus       (bus)
  );

  typedef struct {int ch; int data;} wr_t;
  typedef struct {int ch; int len;}  burst_t;

  wr_t    exp_wr[$];
  burst_t exp_burst[$];
  int     rem[NREQ];
  int     seq[NREQ];
  int     n_tests = 0;
  int     n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int oh_idx(input logic [NREQ-1:0] g);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (g[i]) r = (r == -1) ? i : -2;
    return r;
  endfunction

  // word value encodes channel in bits [7:6] and sequence number in [5:0]
  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]          = (rem[i] > 0);
      bus.req_data[i*DW +: DW]  = DW'(i*64 + seq[i]);
    end
  endtask

  task automatic load(input int ch, input int n);
    rem[ch] = n;
    seq[ch] = 0;
    drive();
  endtask

  task automatic push_wr(input int ch, input int from, input int cnt);
    for (int s = 0; s < cnt; s++) exp_wr.push_back('{ch, ch*64 + from + s});
  endtask

  task automatic push_burst(input int ch, input int len);
    exp_burst.push_back('{ch, len});
  endtask

  task automatic wait_seq(input int ch, input int n, input int budget);
    int ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #2;
      if (seq[ch] == n) begin ok = 1; break; end
    end
    chk("wait_seq", ok, 1);
  endtask

  task automatic wait_done(input int budget);
    int ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #2;
      if (rem[0] == 0 && rem[1] == 0 && rem[2] == 0 && rem[3] == 0 &&
          bus.grant == '0 && exp_wr.size() == 0 && exp_burst.size() == 0) begin
        ok = 1; break;
      end
    end
    chk("drain", ok, 1);
    chk("wr_queue_left", exp_wr.size(), 0);
    chk("burst_queue_left", exp_burst.size(), 0);
  endtask

  task automatic wait_grant(input string name, input int exp_mask);
    int ok = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.grant != '0) begin ok = 1; break; end
    end
    chk({name, "_seen"}, ok, 1);
    chk(name, int'(bus.grant), exp_mask);
    @(posedge clk); #2;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_grant"}, int'(bus.grant), 0);
    chk({tag, "_ready"}, int'(bus.req_ready), 0);
    chk({tag, "_wr_en"}, int'(bus.fifo_wr_en), 0);
    chk({tag, "_din"}, int'(bus.fifo_din), 0);
    chk({tag, "_done"}, int'(bus.burst_done), 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) begin rem[i] = 0; seq[i] = 0; end
    drive();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // producer model: handshake sampled at negedge, consumed just after the edge
  initial begin : producer
    logic [NREQ-1:0] hs;
    forever begin
      @(negedge clk);
      hs = bus.req_valid & bus.req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) if (hs[i]) begin rem[i]--; seq[i]++; end
      drive();
    end
  end

  initial begin : monitor
    int beats, ch_last, gch;
    wr_t    w;
    burst_t b;
    beats = 0;
    ch_last = -1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin beats = 0; continue; end
      gch = oh_idx(bus.grant);
      if (bus.fifo_wr_en) begin
        chk("wr_safe", int'(bus.fifo_full | bus.fifo_wr_rst_busy), 0);
        if (exp_wr.size() == 0) chk("unexpected_wr", 1, 0);
        else begin
          w = exp_wr.pop_front();
          chk("wr_ch", gch, w.ch);
          chk("wr_data", int'(bus.fifo_din), w.data);
        end
        beats++;
        ch_last = gch;
      end
      if (bus.burst_done) begin
        chk("done_grant_clear", int'(bus.grant), 0);
        if (exp_burst.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          b = exp_burst.pop_front();
          chk("burst_ch", ch_last, b.ch);
          chk("burst_len", beats, b.len);
        end
        beats = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int ok;
    bus.fifo_full        = 1'b0;
    bus.fifo_wr_rst_busy = 1'b0;
`ifdef FIFO_WR_ARB_STATS_EN
    stall_clr = 1'b0;
`endif
    for (int i = 0; i < NREQ; i++) begin rem[i] = 0; seq[i] = 0; end
    drive();
    repeat (3) @(posedge clk);
    #1 check_zero_outputs("rst");
    @(posedge clk); #2 rst_n = 1'b1;

    // channel 1 alone, 40 words: bursts of 16, 16, 8
    push_wr(1, 0, 40);
    push_burst(1, 16); push_burst(1, 16); push_burst(1, 8);
    load(1, 40);
    wait_done(200);

    // all channels valid after reset: order 0,1,2,3,0 with 16 words each
    apply_reset();
    push_wr(0, 0, 16); push_wr(1, 0, 16); push_wr(2, 0, 16); push_wr(3, 0, 16); push_wr(0, 16, 16);
    push_burst(0, 16); push_burst(1, 16); push_burst(2, 16); push_burst(3, 16); push_burst(0, 16);
    load(0, 32); load(1, 16); load(2, 16); load(3, 16);
    wait_done(300);

    // fifo_full for 5 cycles after word 6 of channel 2
    push_wr(2, 0, 16); push_burst(2, 16);
    load(2, 16);
    wait_seq(2, 6, 100);
    bus.fifo_full = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_wr_en", int'(bus.fifo_wr_en), 0);
      chk("stall_ready2", int'(bus.req_ready[2]), 0);
      chk("stall_grant", int'(bus.grant), 4);
      @(posedge clk); #2;
    end
    bus.fifo_full = 1'b0;
    wait_done(100);
`ifdef FIFO_WR_ARB_STATS_EN
    chk("stall_cnt", int'(stall_cnt), 5);
`endif

    // channel 0 gaps after 3 words, channel 1 follows after one IDLE cycle
    push_wr(0, 0, 3); push_wr(1, 0, 4);
    push_burst(0, 3); push_burst(1, 4);
    load(0, 3); load(1, 4);
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.burst_done) begin ok = 1; break; end
    end
    chk("gap_done_seen", ok, 1);
    chk("gap_idle_grant", int'(bus.grant), 0);
    @(negedge clk);
    chk("gap_next_grant", int'(bus.grant), 2);
    @(posedge clk); #2;
    wait_done(100);

    // write-reset busy aborts a channel 3 burst; channel 0 goes next
    push_wr(3, 0, 5); push_burst(3, 5);
    push_wr(0, 0, 4); push_burst(0, 4);
    push_wr(3, 5, 11); push_burst(3, 11);
    load(3, 16); load(0, 4);
    wait_seq(3, 5, 100);
    bus.fifo_wr_rst_busy = 1'b1;
    @(negedge clk);
    chk("abort_wr_en", int'(bus.fifo_wr_en), 0);
    chk("abort_ready", int'(bus.req_ready), 0);
    @(posedge clk); #2;
    repeat (2) begin
      @(negedge clk);
      chk("busy_no_grant", int'(bus.grant), 0);
      @(posedge clk); #2;
    end
    bus.fifo_wr_rst_busy = 1'b0;
    wait_grant("post_busy_grant", 1);
    wait_done(150);

    // reset during a channel 1 burst; channel 0 wins first afterwards
    push_wr(1, 0, 4);
    load(1, 16);
    wait_seq(1, 4, 100);
    rst_n = 1'b0;
    #1 check_zero_outputs("midrst");
`ifdef FIFO_WR_ARB_STATS_EN
    chk("midrst_stall_cnt", int'(stall_cnt), 0);
`endif
    push_wr(0, 0, 2); push_burst(0, 2);
    push_wr(1, 4, 12); push_burst(1, 12);
    load(0, 2);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_grant("post_rst_grant", 1);
    wait_done(150);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one dcfifo write port among NREQ producer channels. Grants one channel at a time for bursts of up to BURST_LEN words and passes that channel's data straight to the FIFO write port. Never writes while the FIFO is full or in write-side reset. Sits entirely in the FIFO write-clock domain, between the producers and the FIFO's din/wr_en inputs.

## Interface
Parameters:
- NREQ, 4, number of requester channels (2..8)
- DW, 8, data width; equals FIFO din width
- BURST_LEN, 16, maximum words per grant (1..255)

Ports:
- clk  in  1  write-domain clock, same clock as FIFO wr_clk
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-channel word valid
- req_data  in  NREQ*DW  channel i occupies bits [i*DW +: DW]
- req_ready  out  NREQ  per-channel accept; transfer on valid & ready in the same cycle
- grant  out  NREQ  one-hot current owner, registered; all zero when idle
- fifo_wr_en  out  1  FIFO write enable
- fifo_din  out  DW  FIFO write data
- fifo_full  in  1  FIFO full flag
- fifo_wr_rst_busy  in  1  FIFO write-side reset busy
- burst_done  out  1  one-cycle pulse, registered, when a grant ends for any reason

## Operation
- The FSM has 2 states: IDLE and BURST. A 3-bit round-robin pointer rr_ptr names the highest-priority channel. A beat counter beat_cnt runs 0..BURST_LEN.
- IDLE:
  - If fifo_wr_rst_busy=0 and any req_valid=1, grant the first valid channel found searching from rr_ptr upward with wrap.
  - Set grant[k], clear beat_cnt, go to BURST.
  - Otherwise stay in IDLE.
- BURST:
  - req_ready[k] = grant[k] & ~fifo_full & ~fifo_wr_rst_busy, combinational. All other req_ready bits are 0.
  - fifo_wr_en = req_valid[k] & req_ready[k], combinational.
  - fifo_din = req_data[k] when grant[k] is set, else 0.
  - Each transfer increments beat_cnt.
- Burst ends, returning to IDLE on the next edge, on any of:
  - The transfer that makes beat_cnt = BURST_LEN.
  - req_valid[k]=0 in a cycle where req_ready[k]=1 (producer gap).
  - fifo_wr_rst_busy=1 (abort).
- On burst end:
  - grant clears.
  - rr_ptr = (k+1) mod NREQ.
  - burst_done pulses for one cycle.
- fifo_full while valid is a stall, not an end. The burst holds with no beats counted.
- Words are never dropped or duplicated. fifo_wr_en is never 1 while fifo_full=1 or fifo_wr_rst_busy=1.

## Timing
- Reset values (async, rst_n=0):
  - state=IDLE, rr_ptr=0, beat_cnt=0
  - grant=0, burst_done=0
  - req_ready=0, fifo_wr_en=0, fifo_din=0
- Arbitration latency: a request seen in IDLE at edge n produces grant at edge n+1. The first word can transfer in the cycle after edge n+1.
- Data path latency is 0 cycles: req_data to fifo_din is combinational.
- Per-grant overhead is exactly one IDLE cycle between consecutive bursts. Back-to-back requests therefore sustain BURST_LEN/(BURST_LEN+1) throughput.
- Deassertion of fifo_full re-enables req_ready in the same cycle.
- rst_n asserted mid-burst clears the grant immediately. No partial state survives.

## Configuration
- Macro: FIFO_WR_ARB_STATS_EN.
- Defined:
  - Adds output stall_cnt (16 bits).
  - stall_cnt counts cycles in BURST with req_valid[k]=1 and fifo_full=1, saturating at 16'hFFFF.
  - Adds input stall_clr (1 bit), which synchronously zeroes stall_cnt.
  - stall_cnt resets to 0.
- Undefined: neither port exists, and no counter logic is synthesised.

## Test plan
- Channel 1 only, valid held high for 40 words, BURST_LEN=16, FIFO never full:
  - Three grants to channel 1 of 16, 16 and 8 words.
  - Each burst followed by one IDLE cycle; 3 burst_done pulses.
  - fifo_din matches the channel 1 sequence.
- All 4 channels continuously valid after reset:
  - Grant order 0,1,2,3,0.
  - Each grant carries exactly 16 fifo_wr_en cycles.
- fifo_full forced to 1 for 5 cycles mid-burst after word 6 of channel 2:
  - fifo_wr_en=0 and req_ready[2]=0 for those 5 cycles.
  - The grant is held; writes resume with word 7; the burst completes with 16 words total.
- Channel 0 drops req_valid after 3 words:
  - Burst ends, with burst_done high the next cycle.
  - Channel 1 (also valid) is granted after one IDLE cycle.
- fifo_wr_rst_busy pulses high during a channel 3 burst:
  - Writes stop that cycle and the grant clears.
  - No grant is issued until busy=0.
  - The next grant goes to channel 0.
- rst_n low mid-burst:
  - All outputs go to 0 immediately.
  - After release, the first grant goes to channel 0.
  - With FIFO_WR_ARB_STATS_EN defined, stall_cnt=0.
